// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - encodes symbolic instruction requests into MIPS words and writes them to instruction memory
module instr_encoder #(
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              full
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              ready_q, ready_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              done_q, done_d;
    logic              full_q, full_d;
    logic [31:0]       word;
    logic              accept;
    logic              at_last;

    // Opcodes and funct codes match what the main decoder recognises.
    always_comb begin
        word = 32'd0;
        case (in_kind)
            3'd0:    word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100000};
            3'd1:    word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100010};
            3'd2:    word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100100};
            3'd3:    word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100101};
            3'd4:    word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b101010};
            3'd5:    word = {6'b100011, in_rs, in_rt, in_imm};
            3'd6:    word = {6'b101011, in_rs, in_rt, in_imm};
            default: word = {6'b000100, in_rs, in_rt, in_imm};
        endcase
    end

    assign accept  = in_valid & ready_q;
    assign at_last = (ptr_q == LAST_ADDR);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        done_d  = done_q;
        full_d  = full_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_LOAD;
                    ptr_d   = BASE;
                    count_d = '0;
                    done_d  = 1'b0;
                    full_d  = 1'b0;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    we_d    = 1'b1;
                    addr_d  = ptr_q;
                    wdata_d = word;
                    ptr_d   = ptr_q + ADDR_W'(1);
                    count_d = count_q + (ADDR_W+1)'(1);
                    // The pointer must not wrap within a sequence, so the top address ends it.
                    if (in_last || at_last) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        full_d  = at_last;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_LOAD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= BASE;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            count_q <= '0;
            done_q  <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ready_q <= ready_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            done_q  <= done_d;
            full_q  <= full_d;
        end
    end

    assign in_ready  = ready_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign count     = count_q;
    assign done      = done_q;
    assign full      = full_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed vector bench for instr_encoder (default and small full-boundary instance)
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  in_kind = 3'd0;
    logic [4:0]  in_rs = 5'd0;
    logic [4:0]  in_rt = 5'd0;
    logic [4:0]  in_rd = 5'd0;
    logic [15:0] in_imm = 16'd0;
    logic        in_last = 1'b0;

    logic        a_ready, a_we, a_done, a_full;
    logic [5:0]  a_addr;
    logic [31:0] a_wdata;
    logic [6:0]  a_count;

    logic        b_ready, b_we, b_done, b_full;
    logic [1:0]  b_addr;
    logic [31:0] b_wdata;
    logic [2:0]  b_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(6), .BASE_ADDR(0)) dut_a (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(a_ready),
        .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .in_last(in_last), .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wdata),
        .count(a_count), .done(a_done), .full(a_full)
    );

    instr_encoder #(.ADDR_W(2), .BASE_ADDR(1)) dut_b (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(b_ready),
        .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .in_last(in_last), .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata),
        .count(b_count), .done(b_done), .full(b_full)
    );

    typedef struct {
        logic [2:0]  kind;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic [31:0] word;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input vec_t v, input logic last);
        in_valid = 1'b1;
        in_kind  = v.kind;
        in_rs    = v.rs;
        in_rt    = v.rt;
        in_rd    = v.rd;
        in_imm   = v.imm;
        in_last  = last;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int nwr;
        // R-types carry a junk immediate and I-types a nonzero rd; both must be ignored.
        vecs[0] = '{3'd0, 5'd8,  5'd9, 5'd10, 16'hFFFF, 32'h01095020};
        vecs[1] = '{3'd1, 5'd8,  5'd9, 5'd10, 16'hFFFF, 32'h01095022};
        vecs[2] = '{3'd2, 5'd8,  5'd9, 5'd10, 16'hFFFF, 32'h01095024};
        vecs[3] = '{3'd3, 5'd8,  5'd9, 5'd10, 16'hFFFF, 32'h01095025};
        vecs[4] = '{3'd4, 5'd8,  5'd9, 5'd10, 16'hFFFF, 32'h0109502A};
        vecs[5] = '{3'd5, 5'd29, 5'd8, 5'd10, 16'h0004, 32'h8FA80004};
        vecs[6] = '{3'd6, 5'd29, 5'd8, 5'd10, 16'hFFFC, 32'hAFA8FFFC};
        vecs[7] = '{3'd7, 5'd8,  5'd9, 5'd10, 16'h0003, 32'h11090003};

        @(negedge clk);
        tick();
        chk("rst_ready", 32'(a_ready), 32'd0);
        chk("rst_we",    32'(a_we),    32'd0);
        chk("rst_addr",  32'(a_addr),  32'd0);
        chk("rst_wdata", a_wdata,      32'd0);
        chk("rst_count", 32'(a_count), 32'd0);
        chk("rst_done",  32'(a_done),  32'd0);
        chk("rst_full",  32'(a_full),  32'd0);
        chk("rst_b_ready", 32'(b_ready), 32'd0);
        reset = 1'b0;

        pulse_start();
        chk("start_ready_a", 32'(a_ready), 32'd1);
        chk("start_ready_b", 32'(b_ready), 32'd1);

        drive(vecs[0], 1'b1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("add_we",    32'(a_we),    32'd1);
        chk("add_addr",  32'(a_addr),  32'd0);
        chk("add_wdata", a_wdata,      32'h01095020);
        chk("add_count", 32'(a_count), 32'd1);
        chk("add_done",  32'(a_done),  32'd1);
        chk("add_full",  32'(a_full),  32'd0);
        chk("add_ready", 32'(a_ready), 32'd0);
        chk("add_b_addr", 32'(b_addr), 32'd1);
        tick();
        chk("hold_we",    32'(a_we),   32'd0);
        chk("hold_addr",  32'(a_addr), 32'd0);
        chk("hold_wdata", a_wdata,     32'h01095020);

        pulse_start();
        chk("restart_count", 32'(a_count), 32'd0);
        chk("restart_done",  32'(a_done),  32'd0);

        for (int i = 0; i < 8; i++) begin
            drive(vecs[i], 1'(i == 7));
            tick();
            chk($sformatf("tbl%0d_we", i),    32'(a_we),    32'd1);
            chk($sformatf("tbl%0d_addr", i),  32'(a_addr),  32'(i));
            chk($sformatf("tbl%0d_wdata", i), a_wdata,      vecs[i].word);
            chk($sformatf("tbl%0d_count", i), 32'(a_count), 32'(i + 1));
            chk($sformatf("tbl%0d_done", i),  32'(a_done),  32'(i == 7));
            chk($sformatf("tbl%0d_b_we", i),  32'(b_we),    32'(i < 3));
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        tick();
        chk("tbl_end_we",    32'(a_we),    32'd0);
        chk("tbl_end_addr",  32'(a_addr),  32'd7);
        chk("tbl_end_wdata", a_wdata,      32'h11090003);
        chk("tbl_end_ready", 32'(a_ready), 32'd0);

        pulse_start();
        nwr = 0;
        for (int i = 0; i < 6; i++) begin
            drive(vecs[i], 1'(i == 2));
            tick();
            if (a_we) nwr++;
            chk($sformatf("last%0d_we", i), 32'(a_we), 32'(i < 3));
            if (i < 3) begin
                chk($sformatf("last%0d_addr", i),  32'(a_addr), 32'(i));
                chk($sformatf("last%0d_wdata", i), a_wdata,     vecs[i].word);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("last_writes", 32'(nwr),     32'd3);
        chk("last_count",  32'(a_count), 32'd3);
        chk("last_done",   32'(a_done),  32'd1);
        chk("last_full",   32'(a_full),  32'd0);
        chk("last_ready",  32'(a_ready), 32'd0);
        chk("last_b_count", 32'(b_count), 32'd3);
        chk("last_b_done",  32'(b_done),  32'd1);
        chk("last_b_full",  32'(b_full),  32'd1);

        pulse_start();
        chk("full_start_count", 32'(b_count), 32'd0);
        chk("full_start_done",  32'(b_done),  32'd0);
        chk("full_start_full",  32'(b_full),  32'd0);
        nwr = 0;
        for (int i = 0; i < 5; i++) begin
            drive(vecs[i], 1'b0);
            tick();
            if (b_we && b_addr == 2'd0) nwr++;
            chk($sformatf("full%0d_we", i), 32'(b_we), 32'(i < 3));
            if (i < 3) begin
                chk($sformatf("full%0d_addr", i),  32'(b_addr), 32'(i + 1));
                chk($sformatf("full%0d_wdata", i), b_wdata,     vecs[i].word);
            end
        end
        in_valid = 1'b0;
        tick();
        chk("full_addr0_writes", 32'(nwr),    32'd0);
        chk("full_we",    32'(b_we),    32'd0);
        chk("full_done",  32'(b_done),  32'd1);
        chk("full_full",  32'(b_full),  32'd1);
        chk("full_count", 32'(b_count), 32'd3);
        chk("full_a_count", 32'(a_count), 32'd5);

        pulse_start();
        chk("rs_b_count", 32'(b_count), 32'd0);
        chk("rs_b_done",  32'(b_done),  32'd0);
        chk("rs_b_full",  32'(b_full),  32'd0);
        chk("rs_b_ready", 32'(b_ready), 32'd1);
        chk("rs_a_ready", 32'(a_ready), 32'd1);
        chk("rs_a_count", 32'(a_count), 32'd5);
        drive(vecs[1], 1'b0);
        tick();
        in_valid = 1'b0;
        chk("rs_b_we",    32'(b_we),    32'd1);
        chk("rs_b_addr",  32'(b_addr),  32'd1);
        chk("rs_b_cnt1",  32'(b_count), 32'd1);
        chk("rs_a_addr",  32'(a_addr),  32'd5);
        chk("rs_a_cnt6",  32'(a_count), 32'd6);

        drive(vecs[2], 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_we",    32'(a_we),    32'd0);
        chk("mid_addr",  32'(a_addr),  32'd0);
        chk("mid_wdata", a_wdata,      32'd0);
        chk("mid_count", 32'(a_count), 32'd0);
        chk("mid_done",  32'(a_done),  32'd0);
        chk("mid_full",  32'(a_full),  32'd0);
        chk("mid_ready", 32'(a_ready), 32'd0);
        chk("mid_b_we",  32'(b_we),    32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("idle%0d_we", i),    32'(a_we),    32'd0);
            chk($sformatf("idle%0d_ready", i), 32'(a_ready), 32'd0);
            chk($sformatf("idle%0d_b_we", i),  32'(b_we),    32'd0);
        end
        in_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Encodes symbolic instruction requests (operation kind plus register and immediate fields) into 32-bit MIPS machine words and writes them sequentially into instruction memory. It is the encoding counterpart of the main decoder: it produces exactly the opcodes the decoder recognises (R-type 000000, lw 100011, sw 101011, beq 000100). It sits between the test/boot host and the instruction-memory write port, and is used to load programs before the processor is released.

## Interface

Parameters:
- ADDR_W, 6: instruction-memory word-address width.
- BASE_ADDR, 0: first word address written after each start; must be less than 2^ADDR_W.

Ports:
- clk  input  1  rising-edge clock; the block uses only this clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  arms a new load sequence; takes effect only in IDLE or DONE.
- in_valid  input  1  request valid.
- in_ready  output  1  block accepts a request this cycle.
- in_kind  input  3  operation: 0 add, 1 sub, 2 and, 3 or, 4 slt, 5 lw, 6 sw, 7 beq.
- in_rs  input  5  rs field.
- in_rt  input  5  rt field.
- in_rd  input  5  rd field; ignored for kinds 5–7.
- in_imm  input  16  immediate; ignored for kinds 0–4.
- in_last  input  1  marks the final instruction of the program.
- mem_we  output  1  instruction-memory write enable, one cycle per word.
- mem_addr  output  ADDR_W  word address.
- mem_wdata  output  32  encoded instruction.
- count  output  ADDR_W+1  number of words written since the last start.
- done  output  1  load sequence finished.
- full  output  1  sequence ended because the last memory address was written.

## Operation

- States are IDLE, LOAD and DONE.
- Transitions:
  - Reset goes to IDLE.
  - IDLE goes to LOAD on start.
  - LOAD goes to DONE on an accepted request with in_last=1, or on an accepted request at address 2^ADDR_W−1.
  - DONE goes to LOAD on start.
- Entering LOAD sets the write pointer to BASE_ADDR and clears count, done and full.
- in_ready is 1 only in LOAD. It is 0 in IDLE and DONE, so in_valid in those states is ignored.
- A request is accepted when in_valid and in_ready are both 1 at a rising edge.
- Encoding rules:
  - R-type words are {000000, rs, rt, rd, 00000, funct}.
  - The funct code is add 100000, sub 100010, and 100100, or 100101, slt 101010.
  - lw words are {100011, rs, rt, imm}.
  - sw words are {101011, rs, rt, imm}.
  - beq words are {000100, rs, rt, imm}.
- The immediate is passed through unchanged; no sign handling is applied.
- For each accepted request:
  - mem_addr takes the current pointer.
  - The pointer increments by 1, modulo 2^ADDR_W.
  - count increments by 1.
- The pointer never wraps inside a sequence. Accepting a request at address 2^ADDR_W−1 forces DONE and sets full=1.
- If in_last and the last address coincide, the block sets both done and full.
- done and full are held until the next start or reset.
- start while in LOAD is ignored.
- Reset outputs: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, count=0, done=0, full=0.

## Timing

- All outputs are registered.
- Latency: a request accepted at edge k produces mem_we=1 with its mem_addr and mem_wdata in the cycle after edge k.
- mem_we is high for exactly one cycle per accepted request. mem_addr and mem_wdata hold their last values while mem_we=0.
- Throughput is one word per cycle; back-to-back accepts produce consecutive mem_we pulses.
- start at edge k: in_ready=1 from the cycle after edge k.
- Final accept at edge k (either cause):
  - in_ready=0 from the cycle after edge k.
  - done=1 (and full, if applicable) is asserted in the same cycle as the final mem_we.
- count reflects the accepted word in the same cycle as its mem_we.
- Reset asserted mid-sequence (synchronous) cancels any pending write: mem_we=0 in the cycle after the reset edge, and the state returns to IDLE.

## Test plan

- Encode add: start, then kind 0, rs=8, rt=9, rd=10 → one mem_we pulse with addr 0, wdata 0x01095020, count=1.
- Encode the remaining types back-to-back (with in_rd left nonzero for the I-types, which must be ignored) → four consecutive mem_we pulses at addr 0,1,2,3:
  - slt rs=8 rt=9 rd=10 → 0x0109502A.
  - lw rs=29 rt=8 imm=0x0004 → 0x8FA80004.
  - sw rs=29 rt=8 imm=0xFFFC → 0xAFA8FFFC.
  - beq rs=8 rt=9 imm=0x0003 → 0x11090003.
- in_last on the third word, with in_valid held high afterwards → exactly 3 writes; in_ready=0 after the third accept; done=1, full=0, count=3; extra in_valid is ignored.
- Full boundary with ADDR_W=2, BASE_ADDR=1: stream 5 requests → writes to addr 1,2,3 only; done=1, full=1, count=3; no write to addr 0.
- Restart: start in DONE → pointer returns to BASE_ADDR; count, done and full are cleared; the next word is written at BASE_ADDR.
- Reset mid-load: reset asserted in the same cycle as an accept → no mem_we in the next cycle; all outputs at their reset values; state IDLE; in_valid ignored until start.
